// File: rtl/serial_subtractor_if.sv
// Handshake and data bundle for serial_subtractor.
// master: requester driving start/a/b; slave: the subtractor.
interface serial_subtractor_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             diff_bit;
    logic             diff_bit_valid;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow, diff_bit, diff_bit_valid
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow, diff_bit, diff_bit_valid
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b, one bit per clock, LSB first,
// built from a full-subtractor cell and a borrow flip-flop.
// Optional macro SERIAL_SUB_SAT_EN: unsigned saturation of diff to 0 when
// the final borrow is set (serial diff_bit stream still carries wrapped bits).
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input logic                clk,
    input logic                rst,
    serial_subtractor_if.slave sub_if
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bin_q, bin_d;
    logic             borrow_q, borrow_d;
    logic             dbit_q, dbit_d;
    logic             dval_q, dval_d;

    logic             a0, b0;
    logic             d_cell, bout_cell;
    logic             last_bit;
    logic             busy_c, done_c;

    // Full-subtractor cell on the current LSBs and the stored borrow
    assign a0        = a_sh_q[0];
    assign b0        = b_sh_q[0];
    assign d_cell    = a0 ^ b0 ^ bin_q;
    assign bout_cell = (~a0 & b0) | (~(a0 ^ b0) & bin_q);
    assign last_bit  = (state_q == RUN) && (cnt_q == CNT_W'(WIDTH - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (sub_if.start) state_d = RUN;
            RUN:     if (last_bit)     state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Moore outputs decoded from the state
    always_comb begin
        busy_c = 1'b0;
        done_c = 1'b0;
        case (state_q)
            RUN: begin
                busy_c = 1'b1;
            end
            DONE: begin
                busy_c = 1'b1;
                done_c = 1'b1;
            end
            default: begin
                busy_c = 1'b0;
                done_c = 1'b0;
            end
        endcase
    end

    // Datapath next-state: operand capture, bit step, result accumulation
    always_comb begin
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        diff_d   = diff_q;
        cnt_d    = cnt_q;
        bin_d    = bin_q;
        borrow_d = borrow_q;
        dbit_d   = dbit_q;
        dval_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (sub_if.start) begin
                    a_sh_d = sub_if.a;
                    b_sh_d = sub_if.b;
                    bin_d  = 1'b0;
                    cnt_d  = '0;
                end
            end
            RUN: begin
                dbit_d = d_cell;
                dval_d = 1'b1;
                // New bit enters at the MSB; after WIDTH shifts bit 0 holds the LSB
                diff_d = {d_cell, diff_q[WIDTH-1:1]};
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                bin_d  = bout_cell;
                cnt_d  = cnt_q + CNT_W'(1);
                if (last_bit) begin
                    borrow_d = bout_cell;
`ifdef SERIAL_SUB_SAT_EN
                    if (bout_cell) begin
                        diff_d = '0;
                    end
`endif
                end
            end
            default: begin
                dval_d = 1'b0;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            bin_q    <= 1'b0;
            borrow_q <= 1'b0;
            dbit_q   <= 1'b0;
            dval_q   <= 1'b0;
        end else begin
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            diff_q   <= diff_d;
            cnt_q    <= cnt_d;
            bin_q    <= bin_d;
            borrow_q <= borrow_d;
            dbit_q   <= dbit_d;
            dval_q   <= dval_d;
        end
    end

    assign sub_if.busy           = busy_c;
    assign sub_if.done           = done_c;
    assign sub_if.diff           = diff_q;
    assign sub_if.borrow         = borrow_q;
    assign sub_if.diff_bit       = dbit_q;
    assign sub_if.diff_bit_valid = dval_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=4): reset, vector table,
// back-to-back starts, reset mid-operation, and randomized operands.
module tb_serial_subtractor;
    localparam int W = 4;

`ifdef SERIAL_SUB_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    serial_subtractor_if #(.WIDTH(W)) sif ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .sub_if (sif)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           exp_diff;    // wrapped modulo 2^W
        int           exp_borrow;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One full operation: start pulse, scramble inputs after capture,
    // collect the serial stream, check latency, result and hold behaviour.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input int exp_d, input int exp_b, input string tag);
        int           cyc;
        int           nb;
        logic [W-1:0] bits;
        bit           seen;
        int           fin;
        cyc  = 0;
        nb   = 0;
        bits = '0;
        seen = 1'b0;
        fin  = (SAT && exp_b != 0) ? 0 : exp_d;
        @(negedge clk);
        sif.start = 1'b1;
        sif.a     = a;
        sif.b     = b;
        @(posedge clk);
        while (!seen && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (sif.diff_bit_valid) begin
                if (nb < W) bits[nb] = sif.diff_bit;
                nb++;
            end
            if (sif.done) seen = 1'b1;
            if (cyc == 1) begin
                sif.start = 1'b0;
                sif.a     = W'($urandom);
                sif.b     = W'($urandom);
            end
        end
        check({tag, " done_seen"}, 32'(seen), 1);
        check({tag, " latency"}, 32'(cyc), 5);
        check({tag, " nbits"}, 32'(nb), W);
        check({tag, " serial"}, 32'(bits), 32'(exp_d));
        check({tag, " diff"}, 32'(sif.diff), 32'(fin));
        check({tag, " borrow"}, 32'(sif.borrow), 32'(exp_b));
        check({tag, " busy_at_done"}, 32'(sif.busy), 1);
        @(negedge clk);
        check({tag, " done_pulse"}, 32'(sif.done), 0);
        check({tag, " busy_after"}, 32'(sif.busy), 0);
        check({tag, " diff_held"}, 32'(sif.diff), 32'(fin));
    endtask

    initial begin
        vec_t vecs[9];
        int   pulses;
        int   first_cyc;
        int   last_cyc;
        int   gap_ok;
        int   stray;

        vecs[0] = '{4'd9,  4'd3,  6,  0};
        vecs[1] = '{4'd3,  4'd9,  10, 1};
        vecs[2] = '{4'd15, 4'd15, 0,  0};
        vecs[3] = '{4'd0,  4'd0,  0,  0};
        vecs[4] = '{4'd0,  4'd1,  15, 1};
        vecs[5] = '{4'd12, 4'd5,  7,  0};
        vecs[6] = '{4'd7,  4'd2,  5,  0};
        vecs[7] = '{4'd15, 4'd0,  15, 0};
        vecs[8] = '{4'd0,  4'd15, 1,  1};

        sif.start = 1'b0;
        sif.a     = '0;
        sif.b     = '0;
        rst       = 1'b1;

        // Reset and idle
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst busy", 32'(sif.busy), 0);
        check("rst done", 32'(sif.done), 0);
        check("rst diff", 32'(sif.diff), 0);
        check("rst borrow", 32'(sif.borrow), 0);
        check("rst diff_bit", 32'(sif.diff_bit), 0);
        check("rst valid", 32'(sif.diff_bit_valid), 0);
        rst   = 1'b0;
        stray = 0;
        repeat (10) begin
            @(negedge clk);
            if (sif.done || sif.busy) stray++;
        end
        check("idle no activity", 32'(stray), 0);

        // Vector table
        for (int i = 0; i < 9; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].exp_diff, vecs[i].exp_borrow,
                  $sformatf("vec%0d", i));
        end

        // start held high: one result every W+2 cycles
        @(negedge clk);
        sif.start = 1'b1;
        sif.a     = 4'd7;
        sif.b     = 4'd2;
        @(posedge clk);
        pulses    = 0;
        first_cyc = 0;
        last_cyc  = 0;
        gap_ok    = 1;
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            if (sif.done) begin
                check("hold diff", 32'(sif.diff), 5);
                check("hold borrow", 32'(sif.borrow), 0);
                if (pulses == 0) first_cyc = c;
                else if (c - last_cyc != W + 2) gap_ok = 0;
                last_cyc = c;
                pulses++;
            end
        end
        sif.start = 1'b0;
        check("hold pulses", 32'(pulses), 3);
        check("hold first", 32'(first_cyc), 5);
        check("hold spacing", 32'(gap_ok), 1);
        repeat (8) @(negedge clk);

        // Reset on the second RUN cycle discards the operation
        sif.start = 1'b1;
        sif.a     = 4'd12;
        sif.b     = 4'd5;
        @(posedge clk);
        @(negedge clk);
        sif.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("midrst busy", 32'(sif.busy), 0);
        check("midrst diff", 32'(sif.diff), 0);
        check("midrst valid", 32'(sif.diff_bit_valid), 0);
        stray = 0;
        repeat (10) begin
            @(negedge clk);
            if (sif.done) stray++;
        end
        check("midrst no done", 32'(stray), 0);
        do_op(4'd12, 4'd5, 7, 0, "after_rst");

        // Randomized operands against plain-arithmetic model
        for (int r = 0; r < 30; r++) begin
            int ra;
            int rb;
            ra = int'($urandom_range(0, 15));
            rb = int'($urandom_range(0, 15));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            do_op(W'(ra), W'(rb), (ra - rb + 16) % 16, (ra < rb) ? 1 : 0,
                  $sformatf("rnd%0d", r));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
